// File: rtl/lcd_avalon_ctrl_if.sv
// Avalon-MM slave bus between the LCD message driver and lcd_avalon_ctrl.
interface lcd_avalon_ctrl_if;
  logic       address;
  logic       chipselect;
  logic       byteenable;
  logic       read;
  logic       write;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic       waitrequest;
  logic [1:0] response;

  modport master (
    output address, chipselect, byteenable, read, write, writedata,
    input  readdata, waitrequest, response
  );

  modport slave (
    input  address, chipselect, byteenable, read, write, writedata,
    output readdata, waitrequest, response
  );
endinterface

// File: rtl/lcd_avalon_ctrl.sv
// HD44780 8-bit parallel LCD controller behind an Avalon-MM slave port.
// Runs the power-on init sequence, then turns each accepted write into one
// timed bus cycle (setup, enable pulse, hold, execution wait).
module lcd_avalon_ctrl #(
  parameter int unsigned SETUP_CYC   = 4,
  parameter int unsigned EN_CYC      = 12,
  parameter int unsigned HOLD_CYC    = 2,
  parameter int unsigned EXEC_CYC    = 2000,
  parameter int unsigned CLEAR_CYC   = 82000,
  parameter int unsigned POWERUP_CYC = 750000
) (
  input  logic             clk,
  input  logic             reset_n,
  lcd_avalon_ctrl_if.slave avs,
  output logic [7:0]       LCD_DATA,
  output logic             LCD_RS,
  output logic             LCD_RW,
  output logic             LCD_EN,
  output logic             LCD_ON,
  output logic             LCD_BLON
);

  localparam int unsigned MAX_AB  = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
  localparam int unsigned MAX_CD  = (HOLD_CYC > EXEC_CYC) ? HOLD_CYC : EXEC_CYC;
  localparam int unsigned MAX_EF  = (CLEAR_CYC > POWERUP_CYC) ? CLEAR_CYC : POWERUP_CYC;
  localparam int unsigned MAX_ABC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned MAX_CYC = (MAX_ABC > MAX_EF) ? MAX_ABC : MAX_EF;
  // Counter only ever holds N-1
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT_LOAD,
    SETUP,
    PULSE,
    HOLD,
    EXEC,
    IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             in_init_q, in_init_d;
  logic             init_done_q, init_done_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       last_data_q, last_data_d;
  logic             en_q, en_d;

  logic [7:0]       rom_byte;
  logic             clear_instr;
  logic             busy;
  logic             wr_take;

  // Init ROM: function set, display on, entry increment, clear
  always_comb begin
    rom_byte = 8'h01;
    case (idx_q)
      2'd0:    rom_byte = 8'h38;
      2'd1:    rom_byte = 8'h0C;
      2'd2:    rom_byte = 8'h06;
      default: rom_byte = 8'h01;
    endcase
  end

  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait
  assign clear_instr = ~rs_q & (data_q[7:2] == 6'd0) & (data_q[1:0] != 2'd0);
  assign busy        = (state_q != IDLE);
  assign wr_take     = ~busy & avs.chipselect & avs.write & ~avs.read & avs.byteenable;

  // Next-state, counter reload on state entry, latched bus values
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    in_init_d   = in_init_q;
    init_done_d = init_done_q;
    rs_d        = rs_q;
    data_d      = data_q;
    last_data_d = last_data_q;

    if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    case (state_q)
      PWR_WAIT: begin
        if (cnt_q == '0) begin
          state_d = INIT_LOAD;
          cnt_d   = '0;
        end
      end
      INIT_LOAD: begin
        state_d = SETUP;
        cnt_d   = CNT_W'(SETUP_CYC - 1);
        rs_d    = 1'b0;
        data_d  = rom_byte;
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = PULSE;
          cnt_d   = CNT_W'(EN_CYC - 1);
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = CNT_W'(HOLD_CYC - 1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = EXEC;
          cnt_d   = clear_instr ? CNT_W'(CLEAR_CYC - 1) : CNT_W'(EXEC_CYC - 1);
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          cnt_d = '0;
          if (in_init_q && (idx_q != 2'd3)) begin
            idx_d   = idx_q + 2'd1;
            state_d = INIT_LOAD;
          end else begin
            state_d   = IDLE;
            in_init_d = 1'b0;
            if (in_init_q) begin
              init_done_d = 1'b1;
            end
          end
        end
      end
      IDLE: begin
        cnt_d = '0;
        if (wr_take) begin
          state_d = SETUP;
          cnt_d   = CNT_W'(SETUP_CYC - 1);
          rs_d    = avs.address;
          data_d  = avs.writedata;
          if (avs.address) begin
            last_data_d = avs.writedata;
          end
        end
      end
      default: begin
        state_d = PWR_WAIT;
        cnt_d   = CNT_W'(POWERUP_CYC - 1);
      end
    endcase

    en_d = (state_d == PULSE);
  end

  // State and datapath registers; reset restarts the whole init sequence
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= PWR_WAIT;
      cnt_q       <= CNT_W'(POWERUP_CYC - 1);
      idx_q       <= 2'd0;
      in_init_q   <= 1'b1;
      init_done_q <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      last_data_q <= 8'h00;
      en_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      in_init_q   <= in_init_d;
      init_done_q <= init_done_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      last_data_q <= last_data_d;
      en_q        <= en_d;
    end
  end

  assign avs.waitrequest = busy;
  assign avs.response    = (avs.chipselect & avs.read & avs.write) ? 2'b10 : 2'b00;
  assign avs.readdata    = (avs.chipselect & avs.read)
                           ? (avs.address ? last_data_q : {busy, init_done_q, 6'b000000})
                           : 8'h00;

  assign LCD_DATA = data_q;
  assign LCD_RS   = rs_q;
  assign LCD_EN   = en_q;
  assign LCD_RW   = 1'b0;
  assign LCD_ON   = 1'b1;
  assign LCD_BLON = 1'b1;

endmodule

// File: tb/tb_lcd_avalon_ctrl.sv
// Self-checking bench for lcd_avalon_ctrl: directed scenarios plus random
// Avalon traffic, compared cycle by cycle against a timeline model.
module tb_lcd_avalon_ctrl;

  localparam int SETUP_C = 2;
  localparam int EN_C    = 3;
  localparam int HOLD_C  = 1;
  localparam int EXEC_C  = 10;
  localparam int CLEAR_C = 50;
  localparam int PWR_C   = 20;
  localparam int NEVER   = 32'h7fff_ffff;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon;

  lcd_avalon_ctrl_if bus ();

  lcd_avalon_ctrl #(
    .SETUP_CYC  (SETUP_C),
    .EN_CYC     (EN_C),
    .HOLD_CYC   (HOLD_C),
    .EXEC_CYC   (EXEC_C),
    .CLEAR_CYC  (CLEAR_C),
    .POWERUP_CYC(PWR_C)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .avs     (bus),
    .LCD_DATA(lcd_data),
    .LCD_RS  (lcd_rs),
    .LCD_RW  (lcd_rw),
    .LCD_EN  (lcd_en),
    .LCD_ON  (lcd_on),
    .LCD_BLON(lcd_blon)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Timeline model: each expected enable pulse with its bus value, and the
  // cycle at which the controller becomes idle again.
  typedef struct {
    int         start;
    logic       rs;
    logic [7:0] data;
  } pulse_t;

  pulse_t     expq[$];
  int         idle_at      = NEVER;
  int         init_done_at = NEVER;
  logic [7:0] last_data_m  = 8'h00;
  logic [7:0] init_seq [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
  int         n_rise       = 0;
  int         n_exp_rise   = 0;
  logic       prev_en      = 1'b0;

  function automatic int exec_len(input logic rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? CLEAR_C : EXEC_C;
  endfunction

  function automatic void model_release();
    int t;
    pulse_t p;
    expq.delete();
    t = cyc + PWR_C;
    for (int i = 0; i < 4; i++) begin
      p.start = t + 1 + SETUP_C;
      p.rs    = 1'b0;
      p.data  = init_seq[i];
      expq.push_back(p);
      t = t + 1 + SETUP_C + EN_C + HOLD_C + exec_len(1'b0, init_seq[i]);
    end
    idle_at      = t;
    init_done_at = t;
  endfunction

  function automatic void model_assert();
    expq.delete();
    idle_at      = NEVER;
    init_done_at = NEVER;
    last_data_m  = 8'h00;
  endfunction

  // Per-cycle comparison of every observable output against the model
  always @(negedge clk) begin
    logic   exp_busy, exp_en, init_done_e;
    pulse_t p;
    while (expq.size() > 0 && cyc >= expq[0].start + EN_C + HOLD_C) void'(expq.pop_front());
    exp_busy    = reset_n ? (cyc < idle_at) : 1'b1;
    init_done_e = (cyc >= init_done_at);
    exp_en      = 1'b0;
    if (reset_n && expq.size() > 0 && cyc >= expq[0].start - SETUP_C) begin
      check("lcd_rs", lcd_rs, expq[0].rs);
      check("lcd_data", lcd_data, expq[0].data);
      exp_en = (cyc >= expq[0].start) && (cyc < expq[0].start + EN_C);
      if (cyc == expq[0].start) n_exp_rise++;
    end
    check("waitrequest", bus.waitrequest, exp_busy);
    check("lcd_en", lcd_en, exp_en);
    check("response", bus.response, (bus.chipselect && bus.read && bus.write) ? 2'b10 : 2'b00);
    if (bus.chipselect && bus.read)
      check("readdata", bus.readdata,
            bus.address ? last_data_m : {exp_busy, init_done_e, 6'b000000});
    else
      check("readdata_idle", bus.readdata, 8'h00);
    if (lcd_en && !prev_en) n_rise++;
    prev_en = lcd_en;
    if (reset_n && !exp_busy && bus.chipselect && bus.write && !bus.read && bus.byteenable) begin
      p.start = cyc + 1 + SETUP_C;
      p.rs    = bus.address;
      p.data  = bus.writedata;
      expq.push_back(p);
      idle_at = cyc + 1 + SETUP_C + EN_C + HOLD_C + exec_len(bus.address, bus.writedata);
      if (bus.address) last_data_m = bus.writedata;
    end
  end

  task automatic bus_idle();
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.byteenable = 1'b1;
    bus.address    = 1'b0;
    bus.writedata  = 8'h00;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = (bus.waitrequest === 1'b0);
    end
    check("wait_ready", done, 1'b1);
  endtask

  task automatic present(input logic rd, input logic wr, input logic a,
                         input logic [7:0] d, input logic be);
    next_cycle();
    bus.chipselect = 1'b1;
    bus.read       = rd;
    bus.write      = wr;
    bus.address    = a;
    bus.writedata  = d;
    bus.byteenable = be;
    wait_ready();
  endtask

  task automatic release_bus();
    next_cycle();
    bus_idle();
  endtask

  task automatic do_reset_release();
    next_cycle();
    reset_n = 1'b1;
    model_release();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected < 100000", cyc);
    $fatal(1);
  end

  int         mark, rises;
  int         op;
  logic       ra;
  logic [7:0] rd_byte;
  bit         seen;

  initial begin
    bus_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_waitrequest", bus.waitrequest, 1'b1);
    check("rst_lcd_en", lcd_en, 1'b0);
    check("rst_lcd_rs", lcd_rs, 1'b0);
    check("rst_lcd_data", lcd_data, 8'h00);
    check("rst_response", bus.response, 2'b00);
    check("rst_readdata", bus.readdata, 8'h00);
    check("lcd_rw", lcd_rw, 1'b0);
    check("lcd_on", lcd_on, 1'b1);
    check("lcd_blon", lcd_blon, 1'b1);

    // Power-up init sequence
    do_reset_release();
    mark = cyc;
    wait_ready();
    check("init_length", cyc - mark,
          PWR_C + 4 * (1 + SETUP_C + EN_C + HOLD_C) + 3 * EXEC_C + CLEAR_C);
    check("init_pulses", n_rise, 4);
    present(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    check("status_after_init", bus.readdata, 8'h40);
    release_bus();

    // Single data write and readback
    present(1'b0, 1'b1, 1'b1, 8'h4F, 1'b1);
    mark = cyc;
    release_bus();
    wait_ready();
    check("data_busy_len", cyc - mark - 1, SETUP_C + EN_C + HOLD_C + EXEC_C);
    present(1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
    check("data_readback", bus.readdata, 8'h4F);
    release_bus();

    // Clear display uses the long wait
    present(1'b0, 1'b1, 1'b0, 8'h01, 1'b1);
    mark = cyc;
    release_bus();
    wait_ready();
    check("clear_busy_len", cyc - mark - 1, SETUP_C + EN_C + HOLD_C + CLEAR_C);

    // Write held across busy: two strobes, no loss or duplication
    rises = n_rise;
    present(1'b0, 1'b1, 1'b1, 8'h70, 1'b1);
    present(1'b0, 1'b1, 1'b1, 8'h74, 1'b1);
    release_bus();
    wait_ready();
    check("held_pair_pulses", n_rise - rises, 2);

    // Read and write together: error response, no bus cycle
    rises = n_rise;
    present(1'b1, 1'b1, 1'b0, 8'h55, 1'b1);
    check("rw_response", bus.response, 2'b10);
    release_bus();
    repeat (5) next_cycle();
    check("rw_no_pulse", n_rise - rises, 0);

    // byteenable low: accepted and dropped
    present(1'b0, 1'b1, 1'b1, 8'hAA, 1'b0);
    check("be0_waitrequest", bus.waitrequest, 1'b0);
    release_bus();
    repeat (5) next_cycle();
    check("be0_no_pulse", n_rise - rises, 0);

    // Reset during the enable pulse of a data write
    present(1'b0, 1'b1, 1'b1, 8'h41, 1'b1);
    release_bus();
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = (lcd_en === 1'b1);
    end
    check("saw_pulse_before_reset", seen, 1'b1);
    next_cycle();
    reset_n = 1'b0;
    model_assert();
    #1;
    check("abort_lcd_en", lcd_en, 1'b0);
    check("abort_waitrequest", bus.waitrequest, 1'b1);
    repeat (2) next_cycle();
    rises = n_rise;
    do_reset_release();
    mark = cyc;
    wait_ready();
    check("reinit_length", cyc - mark,
          PWR_C + 4 * (1 + SETUP_C + EN_C + HOLD_C) + 3 * EXEC_C + CLEAR_C);
    check("reinit_pulses", n_rise - rises, 4);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      op      = int'($urandom_range(0, 9));
      ra      = 1'($urandom);
      rd_byte = 8'($urandom);
      repeat ($urandom_range(0, 3)) next_cycle();
      case (op)
        0: begin
          present(1'b0, 1'b1, 1'b0, 8'($urandom_range(1, 3)), 1'b1);
          release_bus();
        end
        1, 2, 3, 4: begin
          present(1'b0, 1'b1, ra, rd_byte, 1'b1);
          release_bus();
        end
        5: begin
          present(1'b0, 1'b1, ra, rd_byte, 1'b0);
          release_bus();
        end
        6, 7: begin
          present(1'b1, 1'b0, ra, 8'h00, 1'b1);
          release_bus();
        end
        8: begin
          present(1'b1, 1'b1, ra, rd_byte, 1'b1);
          release_bus();
        end
        default: begin
          present(1'b0, 1'b1, 1'b1, rd_byte, 1'b1);
          present(1'b0, 1'b1, 1'b1, ~rd_byte, 1'b1);
          release_bus();
        end
      endcase
    end

    wait_ready();
    check("pulse_count", n_rise, n_exp_rise);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_avalon_ctrl.md
Name: lcd_avalon_ctrl

Overview:
- Avalon-MM slave that sits directly downstream of the LCD message driver (CLEAR_DISPLAY plus character writes).
- Converts each accepted 9-bit instruction (address = RS, writedata = byte) into an HD44780-compatible 8-bit parallel bus cycle with setup, enable-pulse, hold and execution timing.
- Runs the power-on init sequence itself and holds waitrequest high while any LCD operation is in progress.

Parameters:
- SETUP_CYC, 4: cycles RS/DATA stable before LCD_EN rises.
- EN_CYC, 12: cycles LCD_EN is held high.
- HOLD_CYC, 2: cycles RS/DATA held after LCD_EN falls.
- EXEC_CYC, 2000: post-pulse wait for normal instructions and data (40 us at 50 MHz).
- CLEAR_CYC, 82000: post-pulse wait for clear/home instructions (1.64 ms).
- POWERUP_CYC, 750000: wait after reset before the first init instruction (15 ms).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  1  0 = instruction register (RS=0), 1 = data register (RS=1)
- chipselect  in  1  slave select
- byteenable  in  1  write byte enable
- read  in  1  read strobe
- write  in  1  write strobe
- writedata  in  8  instruction/character byte
- readdata  out  8  status/readback
- waitrequest  out  1  slave busy; transfer completes only when low
- response  out  2  00 OKAY, 10 SLAVEERROR
- LCD_DATA  out  8  LCD data bus
- LCD_RS  out  1  register select
- LCD_RW  out  1  tied 0 (write only)
- LCD_EN  out  1  enable strobe
- LCD_ON  out  1  panel power, constant 1
- LCD_BLON  out  1  backlight, constant 1

Behaviour:
- **Reset (async, reset_n low):**
  - State = PWR_WAIT; LCD_EN=0, LCD_RS=0, LCD_DATA=0x00, waitrequest=1, readdata=0x00, response=00, init index=0.
  - Reset mid-operation aborts immediately: LCD_EN drops in the same instant and the full init sequence reruns.
- **States:** PWR_WAIT, INIT_LOAD, SETUP, PULSE, HOLD, EXEC, IDLE.
- **Timing counter:** loads N-1 on state entry and leaves the state when it reaches 0, so each state lasts exactly N cycles.
- **PWR_WAIT:** POWERUP_CYC cycles, then INIT_LOAD.
- **INIT_LOAD:** 1 cycle; latches ROM[idx] with RS=0 and goes to SETUP.
  - Init ROM = 0x38 (function set 8-bit/2-line), 0x0C (display on), 0x06 (entry inc), 0x01 (clear).
- **Bus cycle:**
  - SETUP: LCD_EN=0, RS/DATA driven from the latched value.
  - PULSE: LCD_EN=1.
  - HOLD: LCD_EN=0, RS/DATA unchanged.
  - EXEC: RS/DATA unchanged; waits EXEC_CYC, or CLEAR_CYC when RS=0 and data is 0x01, 0x02 or 0x03.
- **After EXEC:** if in init and idx<3, idx++ and go to INIT_LOAD; otherwise go to IDLE.
- **waitrequest:** combinational, equal to (state != IDLE). It is high in every non-IDLE state, whether or not a transfer is being presented.
- **Write acceptance (IDLE only):** a write is accepted in an IDLE cycle with chipselect & write & ~read.
  - Same cycle: latch {address, writedata}.
  - Next cycle: state = SETUP.
  - LCD_EN rises SETUP_CYC+1 cycles after the accept edge.
  - waitrequest is low in the accept cycle and high from the next cycle until EXEC completes.
- **byteenable=0 write:** accepted (waitrequest low) but discarded. No bus cycle; stays IDLE; response 00.
- **Read (any cycle with chipselect & read, valid while waitrequest low):** readdata is combinational.
  - address 0 gives {busy, init_done, 6'b0}.
  - address 1 gives the last accepted data byte.
  - readdata is 0x00 when not reading.
- **read & write together:** response=10, no bus cycle, no state change.
- **Idle bus:** LCD_RS/LCD_DATA keep their last driven values; LCD_EN=0.
- **Back-to-back writes:** a write held high through busy is accepted on the first IDLE cycle. A write presented in the exact cycle EXEC ends sees waitrequest=1 and is taken the following cycle.

Test Plan:
Params for all scenarios: SETUP=2, EN=3, HOLD=1, EXEC=10, CLEAR=50, POWERUP=20.
- Release reset at t0 → waitrequest=1 for 20+4×(2+3+1)+3×10+50+4 INIT_LOAD cycles. LCD_EN shows exactly 4 pulses of 3 cycles with DATA 0x38, 0x0C, 0x06, 0x01 and RS=0. Then IDLE, and a read at address 0 returns 0x40.
- In IDLE, write address=1, data=0x4F ('O') → accepted the same cycle; LCD_EN high for 3 cycles starting 3 cycles later with RS=1, DATA=0x4F; busy for 2+3+1+10 cycles after accept; read at address 1 then returns 0x4F.
- Write address=0, data=0x01 → EXEC lasts 50 cycles; total busy 56 cycles.
- Write held high across busy with data 0x70 then 0x74 → two separate bus cycles, no lost or duplicated strobe, and each EN pulse is exactly 3 cycles.
- Assert reset_n=0 during the PULSE of a data write → LCD_EN=0 immediately, waitrequest=1, and the init sequence restarts from 0x38 after 20 cycles.
- read=write=chipselect=1 in IDLE → response=10 with no LCD_EN activity. A write with byteenable=0 → no LCD_EN activity and waitrequest stays low.
